command_rx: RTL
===============

COMMAND_RX -- requirements
Module: command_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, clk cycles per UART bit (50 MHz / 9600 baud); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx  input  1  serial line from the command transmitter; idle high; asynchronous to clk.
REQ-005 SHALL have port data  output  8  last received byte; bits [2:0] carry the command code.
REQ-006 SHALL have port data_valid  output  1  data holds an unconsumed byte.
REQ-007 SHALL have port data_ready  input  1  consumer accepts data when data_valid && data_ready.
REQ-008 SHALL have port busy  output  1  a frame is in progress (START, DATA or STOP state).
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: completed byte dropped because the buffer was full.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; rx_s denotes the second flop output; all decisions use rx_s only.
REQ-012 SHALL implement states WAIT_HIGH, IDLE, START, DATA, STOP, BREAK, each with a bit-timer counter and a 3-bit bit index.
REQ-013 WAIT_HIGH: go to IDLE on the first cycle rx_s==1; otherwise stay.
REQ-014 IDLE: on rx_s==0, go to START and clear the timer.
REQ-015 START: after floor(CLKS_PER_BIT/2) cycles, sample rx_s; 0 -> DATA with timer and index cleared; 1 -> IDLE (false start, no flags).
REQ-016 DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register LSB-first; after the 8th sample go to STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles, sample rx_s; 1 -> deliver byte, go to IDLE; 0 -> pulse frame_err, discard byte, go to BREAK.
REQ-018 BREAK: stay until rx_s==1, then go to IDLE; no frame starts while the line is held low.
REQ-019 SHALL deliver data and data_valid=1 the cycle after the stop-bit sample; data SHALL be stable while data_valid=1.
REQ-020 SHALL clear data_valid the cycle after data_valid && data_ready; data SHALL keep its value after consumption.
REQ-021 If delivery occurs while data_valid=1 and data_ready=0: pulse overrun, keep the old byte, drop the new one.
REQ-022 If delivery coincides with data_valid && data_ready: accept the new byte, data_valid stays 1, no overrun.
REQ-023 busy SHALL be 1 exactly in START, DATA and STOP.
REQ-024 The timer width SHALL be $clog2(CLKS_PER_BIT)+1 and SHALL never wrap within a bit period.

Reset
REQ-025 With rst=1 at a clk edge: state=WAIT_HIGH, synchronizer flops=1, data=8'h00, data_valid=0, busy=0, frame_err=0, overrun=0, timer=0, index=0.
REQ-026 Reset mid-frame SHALL abort the frame with no flags; a low line after reset SHALL be ignored until it returns high (via WAIT_HIGH).
REQ-027 rst SHALL take priority over all other inputs in the same cycle.

Verification (CLKS_PER_BIT=16)
REQ-028 Frame 0x05, data_ready=0 -> data=8'h05, data_valid=1 one cycle after the stop sample, busy=0, no flags.
REQ-029 Glitch: rx low for 6 cycles -> return to IDLE, no data_valid, no frame_err.
REQ-030 Frame 0xA3 with stop bit low, line high 3 bits later -> frame_err single pulse, data_valid=0, next frame 0x01 received correctly.
REQ-031 Frames 0x11 then 0x22 back-to-back, data_ready=0 -> data=8'h11, one overrun pulse; with data_ready=1 at the delivery cycle -> data=8'h22, no overrun.
REQ-032 rst pulse in the middle of DATA, rx held low afterward -> outputs at reset values, stays in WAIT_HIGH; line high, then frame 0x07 -> data=8'h07.
REQ-033 Random 8N1 frames at ±2% baud skew for 1000 bytes, with random data_ready -> every accepted byte matches, overrun count equals drops.

Source files
------------

// File: rtl/command_rx.sv
// command_rx: 8N1 UART command receiver with a one-byte valid/ready output buffer
module command_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);
  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP, BREAK} state_t;
  state_t r_state, w_next;
  logic r_rx_meta, r_rx_s;
  logic [TW-1:0] r_timer;
  logic [2:0] r_index;
  logic [7:0] r_shift;
  logic w_half, w_full, w_bit, w_deliver, w_ferr, w_primed;
  always_comb begin
    w_half = r_timer == HALF;
    w_full = r_timer == FULL;
    w_primed = r_timer[TW-1:1] != '0;
    busy = r_state == START || r_state == DATA || r_state == STOP;
    w_bit = r_state == DATA && w_full;
    w_deliver = r_state == STOP && w_full && r_rx_s;
    w_ferr = r_state == STOP && w_full && !r_rx_s;
    w_next = r_state;
    case (r_state)
      WAIT_HIGH: w_next = r_rx_s && w_primed ? IDLE : WAIT_HIGH;
      IDLE:      w_next = r_rx_s ? IDLE : START;
      START:     w_next = !w_half ? START : r_rx_s ? IDLE : DATA;
      DATA:      w_next = w_bit && r_index == 3'd7 ? STOP : DATA;
      STOP:      w_next = !w_full ? STOP : r_rx_s ? IDLE : BREAK;
      BREAK:     w_next = r_rx_s ? IDLE : BREAK;
      default:   w_next = WAIT_HIGH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_HIGH;
      r_rx_meta <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_state <= w_next;
      r_rx_meta <= rx;
      r_rx_s <= r_rx_meta;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
      r_index <= '0;
      r_shift <= '0;
    end else begin
      r_timer <= (w_next != r_state || w_bit) ? '0 :
                 (busy || (r_state == WAIT_HIGH && !w_primed)) ? r_timer + 1'b1 : r_timer;
      r_index <= r_state != DATA ? '0 : w_bit ? r_index + 1'b1 : r_index;
      r_shift <= w_bit ? {r_rx_s, r_shift[7:1]} : r_shift;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      frame_err <= w_ferr;
      overrun <= w_deliver && data_valid && !data_ready;
      data_valid <= w_deliver || (data_valid && !data_ready);
      data <= (w_deliver && (!data_valid || data_ready)) ? r_shift : data;
    end
  end
endmodule
